serial_subtractor: RTL and testbench

//   Bit-serial N-bit subtractor: Diff = Minuend - Subtrahend - Borrow_in, one bit per cycle, LSB first.

---
 rtl/serial_subtractor_pkg.sv | 12 +
 rtl/full_subtractor_bit.sv | 16 +
 rtl/serial_subtractor.sv | 113 +++++++++++
 tb/tb_serial_subtractor.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/serial_subtractor_pkg.sv
// rtl/serial_subtractor_pkg.sv - shared types and defaults for the bit-serial subtractor
package serial_subtractor_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/full_subtractor_bit.sv
// rtl/full_subtractor_bit.sv - single-bit full subtractor cell
module full_subtractor_bit (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    // Difference and borrow of a - b - bin
    always_comb begin
        d    = a ^ b ^ bin;
        bout = (~a & b) | (~a & bin) | (b & bin);
    end

endmodule

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial LSB-first subtractor with valid/ready handshakes
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] Minuend,
    input  logic [WIDTH-1:0] Subtrahend,
    input  logic             Borrow_in,
    input  logic             Hold,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Diff,
    output logic             Borrow
);

    // One extra bit so the counter can reach WIDTH without wrapping.
    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d;

    logic             bit_d;
    logic             bit_bout;

    full_subtractor_bit u_cell (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .bin  (borrow_q),
        .d    (bit_d),
        .bout (bit_bout)
    );

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
        end
    end

    // Next-state: load on accept, shift one bit per un-held SHIFT cycle, wait for consumer in DONE.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d      = Minuend;
                    b_d      = Subtrahend;
                    borrow_d = Borrow_in;
                    cnt_d    = '0;
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                if (!Hold) begin
                    a_d      = a_q >> 1;
                    b_d      = b_q >> 1;
                    // New difference bit enters at the MSB so the LSB-first stream lands in place.
                    diff_d   = (diff_q >> 1) | (WIDTH'(bit_d) << (WIDTH - 1));
                    borrow_d = bit_bout;
                    cnt_d    = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_BIT) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Handshake flags follow the state; results come straight from the registers.
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        Diff      = diff_q;
        Borrow    = borrow_q;
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - self-checking bench for serial_subtractor (WIDTH=8)
module tb_serial_subtractor;

    localparam int W = 8;

    logic         Clock;
    logic         Reset;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] Minuend;
    logic [W-1:0] Subtrahend;
    logic         Borrow_in;
    logic         Hold;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] Diff;
    logic         Borrow;

    int checks = 0;
    int errors = 0;

    serial_subtractor #(.WIDTH(W)) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .Minuend    (Minuend),
        .Subtrahend (Subtrahend),
        .Borrow_in  (Borrow_in),
        .Hold       (Hold),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .Diff       (Diff),
        .Borrow     (Borrow)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       bin;
        logic [7:0] d;
        logic       bo;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain integer subtraction, borrow when A < B + Bin.
    function automatic logic [8:0] ref_sub(input logic [7:0] a, input logic [7:0] b, input logic bin);
        int diff;
        logic bo;
        diff = int'(a) - int'(b) - int'(bin);
        bo   = (int'(a) < int'(b) + int'(bin));
        return {bo, diff[7:0]};
    endfunction

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    // Drives one operation through accept, SHIFT (optionally held), DONE (optionally back-pressured).
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic bin,
                          input int hold_at, input int hold_len, input int ready_dly, input bit rnd,
                          output logic [7:0] d, output logic bo, output int lat, output int nholds);
        bit ready_bad;
        bit stable_bad;
        ready_bad  = 0;
        stable_bad = 0;
        check("in_ready_before_accept", in_ready, 1);
        Minuend    = a;
        Subtrahend = b;
        Borrow_in  = bin;
        in_valid   = 1'b1;
        tick();
        in_valid   = 1'b0;
        Minuend    = 8'($urandom);
        Subtrahend = 8'($urandom);
        Borrow_in  = 1'($urandom);
        lat        = 0;
        nholds     = 0;
        while (!out_valid && lat < 200) begin
            if (in_ready) ready_bad = 1;
            if (rnd) begin
                Hold      = ($urandom_range(0, 3) == 0);
                in_valid  = 1'($urandom);
                out_ready = 1'($urandom);
            end else begin
                Hold = (lat >= hold_at && lat < hold_at + hold_len);
            end
            if (Hold) nholds++;
            tick();
            lat++;
        end
        Hold      = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("result_timeout", out_valid, 1);
        d  = Diff;
        bo = Borrow;
        for (int i = 0; i < ready_dly; i++) begin
            if (rnd) begin
                Hold     = 1'($urandom);
                in_valid = 1'($urandom);
            end
            tick();
            if (Diff !== d || Borrow !== bo || out_valid !== 1'b1 || in_ready !== 1'b0) stable_bad = 1;
        end
        Hold      = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("in_ready_low_while_busy", ready_bad, 0);
        check("done_stable_under_backpressure", stable_bad, 0);
        check("out_valid_after_handoff", out_valid, 0);
        check("in_ready_after_handoff", in_ready, 1);
        check("diff_held_after_handoff", Diff, d);
    endtask

    initial begin
        logic [7:0] d;
        logic       bo;
        int         lat;
        int         nh;
        logic [8:0] exp;
        logic [7:0] ra, rb;
        logic       rbin;

        vecs[0] = '{a: 8'h5A, b: 8'h3C, bin: 1'b0, d: 8'h1E, bo: 1'b0};
        vecs[1] = '{a: 8'h00, b: 8'h01, bin: 1'b0, d: 8'hFF, bo: 1'b1};
        vecs[2] = '{a: 8'hFF, b: 8'hFF, bin: 1'b1, d: 8'hFF, bo: 1'b1};
        vecs[3] = '{a: 8'h10, b: 8'h0F, bin: 1'b1, d: 8'h00, bo: 1'b0};
        vecs[4] = '{a: 8'h03, b: 8'h02, bin: 1'b0, d: 8'h01, bo: 1'b0};

        Reset      = 1'b1;
        in_valid   = 1'b0;
        Minuend    = '0;
        Subtrahend = '0;
        Borrow_in  = 1'b0;
        Hold       = 1'b0;
        out_ready  = 1'b0;
        #12;
        check("reset_in_ready", in_ready, 1);
        check("reset_out_valid", out_valid, 0);
        check("reset_diff", Diff, 0);
        check("reset_borrow", Borrow, 0);
        tick();
        Reset = 1'b0;
        tick();

        // Directed vectors, no stall, no back-pressure.
        for (int i = 0; i < 5; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].bin, 0, 0, 0, 0, d, bo, lat, nh);
            check($sformatf("vec%0d_diff", i), d, vecs[i].d);
            check($sformatf("vec%0d_borrow", i), bo, vecs[i].bo);
            check($sformatf("vec%0d_latency", i), lat, 8);
        end

        // Hold for 3 cycles mid-SHIFT, then 5 cycles of back-pressure.
        run_op(8'h80, 8'h01, 1'b0, 3, 3, 5, 0, d, bo, lat, nh);
        check("stall_latency", lat, 11);
        check("stall_diff", d, 8'h7F);
        check("stall_borrow", bo, 0);

        // Reset during SHIFT cycle 4 aborts the operation.
        Minuend    = 8'hAA;
        Subtrahend = 8'h55;
        Borrow_in  = 1'b1;
        in_valid   = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check("midop_in_ready_busy", in_ready, 0);
        #2;
        Reset = 1'b1;
        #1;
        check("midop_reset_out_valid", out_valid, 0);
        check("midop_reset_in_ready", in_ready, 1);
        check("midop_reset_diff", Diff, 0);
        check("midop_reset_borrow", Borrow, 0);
        tick();
        Reset = 1'b0;
        tick();
        check("post_reset_no_result", out_valid, 0);
        run_op(8'h03, 8'h02, 1'b0, 0, 0, 0, 0, d, bo, lat, nh);
        check("post_reset_diff", d, 8'h01);
        check("post_reset_borrow", bo, 0);

        // Randomised operations against the arithmetic reference.
        for (int n = 0; n < 1000; n++) begin
            int gap;
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                Hold      = 1'($urandom);
                out_ready = 1'($urandom);
                tick();
                if (out_valid !== 1'b0) check("idle_out_valid", out_valid, 0);
            end
            Hold      = 1'b0;
            out_ready = 1'b0;
            ra   = 8'($urandom);
            rb   = 8'($urandom);
            rbin = 1'($urandom);
            exp  = ref_sub(ra, rb, rbin);
            run_op(ra, rb, rbin, 0, 0, $urandom_range(0, 3), 1, d, bo, lat, nh);
            check("rand_diff", d, exp[7:0]);
            check("rand_borrow", bo, exp[8]);
            check("rand_latency", lat, 8 + nh);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
